// File: rtl/alu_acc_seq.sv
// alu_acc_seq: sequencing stage that turns an external N-bit combinational
// ALU into a registered accumulator datapath with N/Z/C/V status flags.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   op_valid/op_ready   request handshake (one op in flight at a time)
//   op_code/op_data     operation selector and operand b / load value
//   op_cin              carry-in forwarded to the ALU
//   alu_a/b/cin/sel     registered drive to the external ALU
//   alu_z/alu_co        combinational result and carry back from the ALU
//   acc                 accumulator
//   flag_n/z/c/v        status flags from the last completed legal op
//   res_valid           one-cycle completion pulse
//   err                 qualifies res_valid; set when the op code was illegal
//
// Build option
//   ALU_ACC_SAT_EN      ADD/SUB saturate to max positive / min negative on
//                       signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | ready for a request; op_ready = 1
// EXEC  | ALU settling on the captured op; result written at the next edge
module alu_acc_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic [N-1:0] op_data,
  input  logic         op_cin,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_z,
  input  logic         alu_co,
  output logic [N-1:0] acc,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         res_valid,
  output logic         err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLA  = 4'b1001;
  localparam logic [3:0] OP_CLR  = 4'b1110;
  localparam logic [3:0] OP_LOAD = 4'b1111;

  typedef enum logic [0:0] {IDLE, EXEC} state_t;

  state_t         state, state_nxt;
  logic           accept, done;
  logic [3:0]     sel_q;
  logic [N-1:0]   b_q;
  logic           cin_q;
  logic [N-1:0]   res;
  logic           res_c, res_v, legal;

  assign alu_a   = acc;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;
  assign alu_cin = cin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result selection from the op captured at accept; the ALU has had a full
  // cycle to settle on the registered drive by the time this is used.
  always_comb begin
    res   = acc;
    res_c = 1'b0;
    res_v = 1'b0;
    legal = 1'b1;
    case (sel_q)
      OP_ADD: begin
        res   = alu_z;
        res_c = alu_co;
        res_v = (acc[N-1] == b_q[N-1]) && (alu_z[N-1] != acc[N-1]);
      end
      OP_SUB: begin
        res   = alu_z;
        res_c = alu_co;
        res_v = (acc[N-1] != b_q[N-1]) && (alu_z[N-1] != acc[N-1]);
      end
      OP_AND, OP_OR, OP_XOR: res = alu_z;
      OP_SLA: begin
        res   = alu_z;
        res_c = alu_co;
      end
      OP_LOAD: res = b_q;
      OP_CLR:  res = '0;
      default: legal = 1'b0;
    endcase
`ifdef ALU_ACC_SAT_EN
    // Only ADD/SUB can raise res_v, so no further op qualification needed.
    if (res_v) res = acc[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      acc       <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        sel_q <= op_code;
        b_q   <= op_data;
        cin_q <= op_cin;
      end
      if (done && legal) begin
        acc    <= res;
        flag_n <= res[N-1];
        flag_z <= (res == '0);
        flag_c <= res_c;
        flag_v <= res_v;
      end
      res_valid <= done;
      err       <= done && !legal;
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
module tb_alu_acc_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [3:0]   op_code = '0;
  logic [N-1:0] op_data = '0;
  logic         op_cin = 1'b0;
  logic [N-1:0] alu_a, alu_b, alu_z;
  logic         alu_cin, alu_co;
  logic [3:0]   alu_sel;
  logic [N-1:0] acc;
  logic         flag_n, flag_z, flag_c, flag_v, res_valid, err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_acc = 0, m_n = 0, m_z = 0, m_c = 0, m_v = 0, m_err = 0;

  always #5 clk = ~clk;

  alu_acc_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_data(op_data), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_z(alu_z), .alu_co(alu_co),
    .acc(acc),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .res_valid(res_valid), .err(err)
  );

  // behavioural stand-in for the external combinational ALU
  logic [31:0] sh;
  logic [N:0]  sum;
  always_comb begin
    sh     = 32'(alu_a) << alu_b;
    sum    = '0;
    alu_z  = '0;
    alu_co = 1'b0;
    case (alu_sel)
      4'b0000: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin}; alu_z = sum[N-1:0]; alu_co = sum[N]; end
      4'b0001: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin}; alu_z = sum[N-1:0]; alu_co = sum[N]; end
      4'b0011: alu_z = alu_a & alu_b;
      4'b0100: alu_z = alu_a | alu_b;
      4'b0101: alu_z = alu_a ^ alu_b;
      4'b1001: begin alu_z = sh[N-1:0]; alu_co = sh[N]; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // spec-level arithmetic model of one op
  task automatic model_apply(input int code, input int b, input int cin);
    int r, c, v, s, legal;
    r = m_acc; c = 0; v = 0; legal = 1;
    case (code)
      0: begin r = m_acc + b + cin; c = (r > 15); s = sx(m_acc) + sx(b) + cin; v = (s > 7 || s < -8); end
      1: begin r = m_acc + (15 - b) + cin; c = (r > 15); s = sx(m_acc) + sx(15 - b) + cin; v = (s > 7 || s < -8); end
      3: r = m_acc & b;
      4: r = m_acc | b;
      5: r = m_acc ^ b;
      9: begin r = m_acc * (1 << b); c = (r >> 4) & 1; end
      14: r = 0;
      15: r = b;
      default: legal = 0;
    endcase
    if (legal != 0) begin
`ifdef ALU_ACC_SAT_EN
      if (v != 0) r = (m_acc >= 8) ? 8 : 7;
`endif
      m_acc = r & 15;
      m_z = (m_acc == 0);
      m_n = (m_acc >= 8);
      m_c = c;
      m_v = v;
    end
    m_err = (legal == 0);
  endtask

  task automatic do_op(input int code, input int b, input int cin);
    int k;
    @(negedge clk);
    chk("rv_idle", int'(res_valid), 0);
    op_valid = 1'b1;
    op_code  = 4'(code);
    op_data  = 4'(b);
    op_cin   = 1'(cin);
    k = 0;
    while (!op_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (k == 10) begin
      chk("ready_timeout", int'(op_ready), 1);
      op_valid = 1'b0;
      return;
    end
    @(negedge clk);  // past accept edge E0
    op_valid = 1'b0;
    chk("rv_exec", int'(res_valid), 0);
    chk("ready_exec", int'(op_ready), 0);
    chk("alu_a", int'(alu_a), m_acc);
    chk("alu_b", int'(alu_b), b);
    chk("alu_sel", int'(alu_sel), code);
    chk("alu_cin", int'(alu_cin), cin);
    model_apply(code, b, cin);
    @(negedge clk);  // past capture edge E1
    chk("rv_done", int'(res_valid), 1);
    chk("ready_done", int'(op_ready), 1);
    chk("err", int'(err), m_err);
    chk("acc", int'(acc), m_acc);
    chk("flags", int'({flag_n, flag_z, flag_c, flag_v}), m_n * 8 + m_z * 4 + m_c * 2 + m_v);
  endtask

  task automatic model_reset();
    m_acc = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_err = 0;
  endtask

  initial begin
    int cnt;
    int codes[10];
    codes = '{0, 1, 3, 4, 5, 9, 14, 15, 2, 12};

    rst_n = 1'b0;
    #12;
    chk("rst_acc", int'(acc), 0);
    chk("rst_flags", int'({flag_n, flag_z, flag_c, flag_v}), 0);
    chk("rst_ready", int'(op_ready), 1);
    chk("rst_rv", int'(res_valid), 0);
    chk("rst_alu", int'({alu_a, alu_b, alu_sel, alu_cin}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(15, 1, 0);
    do_op(0, 10, 0);
    chk("load_add", int'(acc), 11);
    chk("load_add_n", int'(flag_n), 1);

    do_op(15, 7, 0);
    do_op(0, 1, 0);
`ifdef ALU_ACC_SAT_EN
    chk("ovf_acc", int'(acc), 7);
`else
    chk("ovf_acc", int'(acc), 8);
`endif
    chk("ovf_v", int'(flag_v), 1);

    do_op(15, 9, 0);
    do_op(5, 9, 0);
    chk("xor_zero", int'({acc, flag_z, flag_c}), 2);

    do_op(15, 11, 0);
    do_op(9, 2, 0);
    chk("sla", int'(acc), 12);

    do_op(15, 6, 0);
    do_op(2, 3, 1);
    chk("illegal_err", int'(err), 1);
    chk("illegal_acc", int'(acc), 6);

    // backpressure: hold a constant ADD 1 for 6 cycles
    do_op(15, 0, 0);
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'b0000; op_data = 4'd1; op_cin = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    for (int i = 0; i < 3; i++) model_apply(0, 1, 0);
    chk("bp_count", cnt, 3);
    chk("bp_acc", int'(acc), m_acc);

    // reset during EXEC discards the op
    do_op(15, 5, 0);
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'b0000; op_data = 4'd2; op_cin = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rv", int'(res_valid), 0);
    @(negedge clk);
    chk("rst_mid_rv2", int'(res_valid), 0);
    chk("rst_mid_acc", int'(acc), 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_rv3", int'(res_valid), 0);

    // randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      do_op(codes[$urandom_range(0, 9)], int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 50; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
